// File: rtl/muldiv_unit.sv
// muldiv_unit
//   Iterative 32x32 multiply / divide unit with HI:LO result registers.
//   Each operation runs through IDLE -> RUN -> FINISH. RUN covers 32
//   iteration cycles plus one commit cycle. hi/lo are written at the edge
//   that enters FINISH, so done is high during FINISH.
//
// Ports
//   clk          : single clock, rising edge
//   rst          : asynchronous reset, active low
//   start        : operation request, accepted only in IDLE
//   op[1:0]      : 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   src_a        : multiplicand / dividend
//   src_b        : multiplier / divisor
//   hilo_we[1:0] : bit1 MTHI, bit0 MTLO (IDLE only, dropped if start is accepted)
//   hilo_wdata   : data for MTHI / MTLO
//   busy         : high in RUN and FINISH
//   done         : one-cycle pulse while the committed result is visible
//   div_by_zero  : qualified by done, division with src_b == 0
//   hi, lo       : HI / LO registers
//
// Configuration
//   MULDIV_DIV_EN : when defined, the divider datapath is built. When it is
//                   undefined, division requests are ignored and
//                   div_by_zero is tied low.
module muldiv_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic [1:0]  hilo_we,
  input  logic [31:0] hilo_wdata,
  output logic        busy,
  output logic        done,
  output logic        div_by_zero,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] opa_q, opa_d;
  logic [63:0] acc_q, acc_d;
  logic        neg_q, neg_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;

  logic        accept;
  logic        signed_op;
  logic [31:0] mag_a, mag_b;
  logic [32:0] mul_sum;
  logic [63:0] mul_next;
  logic [63:0] prod;

`ifdef MULDIV_DIV_EN
  logic        is_div_q, is_div_d;
  logic        neg_rem_q, neg_rem_d;
  logic        dbz_q, dbz_d;
  logic [32:0] div_shift;
  logic [33:0] div_trial;
  logic        div_ok;
  logic [63:0] div_next;
  logic [31:0] quo_fix, rem_fix;
`endif

  // Shared datapath. acc_q holds {partial product, multiplier} for a
  // multiply and {remainder, dividend/quotient} for a divide. opa_q holds
  // the magnitude of the multiplicand or divisor.
  always_comb begin
    signed_op = ~op[0];
    mag_a     = (signed_op && src_a[31]) ? (~src_a + 32'd1) : src_a;
    mag_b     = (signed_op && src_b[31]) ? (~src_b + 32'd1) : src_b;
    mul_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opa_q} : 33'd0);
    mul_next  = {mul_sum, acc_q[31:1]};
    prod      = neg_q ? (~acc_q + 64'd1) : acc_q;
`ifdef MULDIV_DIV_EN
    // Restoring step: shift the next dividend bit into the remainder and
    // keep the subtraction only if it did not go negative.
    div_shift = {acc_q[63:32], acc_q[31]};
    div_trial = {1'b0, div_shift} - {2'b00, opa_q};
    div_ok    = ~div_trial[33];
    div_next  = {(div_ok ? div_trial[31:0] : div_shift[31:0]), acc_q[30:0], div_ok};
    quo_fix   = neg_q ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
    rem_fix   = neg_rem_q ? (~acc_q[63:32] + 32'd1) : acc_q[63:32];
`endif
  end

`ifdef MULDIV_DIV_EN
  assign accept = start && (state_q == IDLE);
`else
  assign accept = start && (state_q == IDLE) && !op[1];
`endif

  // Next-state and register update logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    opa_d   = opa_q;
    acc_d   = acc_q;
    neg_d   = neg_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
`ifdef MULDIV_DIV_EN
    is_div_d  = is_div_q;
    neg_rem_d = neg_rem_q;
    dbz_d     = dbz_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = RUN;
          cnt_d   = 6'd0;
          neg_d   = signed_op && (src_a[31] ^ src_b[31]);
          opa_d   = mag_a;
          acc_d   = {32'd0, mag_b};
`ifdef MULDIV_DIV_EN
          is_div_d  = op[1];
          neg_rem_d = signed_op && src_a[31];
          dbz_d     = op[1] && (src_b == 32'd0);
          if (op[1]) begin
            opa_d = mag_b;
            acc_d = {32'd0, mag_a};
          end
`endif
        end else begin
          if (hilo_we[1]) hi_d = hilo_wdata;
          if (hilo_we[0]) lo_d = hilo_wdata;
        end
      end
      RUN: begin
        // After 32 iterations the extra RUN cycle commits the result.
        if (cnt_q == 6'd32) begin
          state_d = FINISH;
          hi_d    = prod[63:32];
          lo_d    = prod[31:0];
`ifdef MULDIV_DIV_EN
          if (is_div_q) begin
            hi_d = dbz_q ? hi_q : rem_fix;
            lo_d = dbz_q ? lo_q : quo_fix;
          end
`endif
        end else begin
          cnt_d = cnt_q + 6'd1;
          acc_d = mul_next;
`ifdef MULDIV_DIV_EN
          if (is_div_q) acc_d = div_next;
`endif
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 6'd0;
      opa_q   <= 32'd0;
      acc_q   <= 64'd0;
      neg_q   <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
`ifdef MULDIV_DIV_EN
      is_div_q  <= 1'b0;
      neg_rem_q <= 1'b0;
      dbz_q     <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      opa_q   <= opa_d;
      acc_q   <= acc_d;
      neg_q   <= neg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
`ifdef MULDIV_DIV_EN
      is_div_q  <= is_div_d;
      neg_rem_q <= neg_rem_d;
      dbz_q     <= dbz_d;
`endif
    end
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == FINISH);
  assign hi   = hi_q;
  assign lo   = lo_q;
`ifdef MULDIV_DIV_EN
  assign div_by_zero = done && dbz_q;
`else
  assign div_by_zero = 1'b0;
`endif

endmodule

// File: tb/tb_muldiv_unit.sv
// Testbench for muldiv_unit.
// Directed operations push their expected result into a scoreboard queue.
// A monitor on the falling clock edge pops an entry whenever done is high.
// It compares hi/lo/div_by_zero and the done cycle against the entry. One
// cycle later it also checks that busy has fallen.
module tb_muldiv_unit;

  logic        clk, rst, start;
  logic [1:0]  op, hilo_we;
  logic [31:0] src_a, src_b, hilo_wdata;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef struct {
    int unsigned cyc;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
    string       name;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  bit          busy_due = 0;
  logic [31:0] prev_hi, prev_lo;

  muldiv_unit dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
    .hilo_we(hilo_we), .hilo_wdata(hilo_wdata), .busy(busy), .done(done),
    .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst) begin
      busy_due = 0;
    end else begin
      if (busy_due) begin
        checkOutput("busy_fall", {63'd0, busy}, 64'd0);
        checkOutput("done_pulse", {63'd0, done}, 64'd0);
        busy_due = 0;
      end
      if (done) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_done", {63'd0, done}, 64'd0);
        end else begin
          e = sb.pop_front();
          checkOutput({e.name, "_cycle"}, 64'(cyc), 64'(e.cyc));
          checkOutput({e.name, "_hi"}, {32'd0, hi}, {32'd0, e.hi});
          checkOutput({e.name, "_lo"}, {32'd0, lo}, {32'd0, e.lo});
          checkOutput({e.name, "_dbz"}, {63'd0, div_by_zero}, {63'd0, e.dbz});
          busy_due = 1;
        end
      end else begin
        checkOutput("dbz_without_done", {63'd0, div_by_zero}, 64'd0);
      end
    end
  end

  // Issue one operation; returns on the falling edge after acceptance.
  task automatic applyStimulus(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                               input logic [1:0] we, input logic [31:0] wd,
                               input logic [31:0] eh, input logic [31:0] el, input logic ed,
                               input string name);
    exp_t e;
    @(negedge clk);
    op = o; src_a = a; src_b = b; hilo_we = we; hilo_wdata = wd; start = 1'b1;
    e.cyc = cyc + 34; e.hi = eh; e.lo = el; e.dbz = ed; e.name = name;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0; hilo_we = 2'b00;
    src_a = 32'hDEADBEEF; src_b = 32'h0BADF00D; op = ~o;
  endtask

  task automatic waitIdle(input string name);
    bit ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!busy && sb.size() == 0) begin
        ok = 1;
        break;
      end
    end
    if (!ok) checkOutput({name, "_timeout"}, {63'd0, busy}, 64'd0);
  endtask

  task automatic writeHilo(input logic [1:0] we, input logic [31:0] wd);
    @(negedge clk);
    hilo_we = we; hilo_wdata = wd;
    @(negedge clk);
    hilo_we = 2'b00;
  endtask

`ifndef MULDIV_DIV_EN
  task automatic issueIgnored(input logic [1:0] o, input string name);
    @(negedge clk);
    op = o; src_a = 32'd100; src_b = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput({name, "_busy"}, {63'd0, busy}, 64'd0);
    repeat (40) @(negedge clk);
    checkOutput({name, "_hi"}, {32'd0, hi}, 64'h12345678);
    checkOutput({name, "_lo"}, {32'd0, lo}, 64'h0F0F0F0F);
  endtask
`endif

  initial begin
    rst = 1'b1; start = 1'b0; op = 2'b00; src_a = 32'd0; src_b = 32'd0;
    hilo_we = 2'b00; hilo_wdata = 32'd0;
    #1 rst = 1'b0;
    #2;
    checkOutput("reset_busy", {63'd0, busy}, 64'd0);
    checkOutput("reset_done", {63'd0, done}, 64'd0);
    checkOutput("reset_dbz", {63'd0, div_by_zero}, 64'd0);
    checkOutput("reset_hi", {32'd0, hi}, 64'd0);
    checkOutput("reset_lo", {32'd0, lo}, 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    $display("[TB] multiply tests");
    applyStimulus(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 2'b00, 32'd0,
                  32'hFFFFFFFE, 32'h00000001, 1'b0, "multu_max");
    waitIdle("multu_max");

    applyStimulus(OP_MULT, 32'hFFFFFFFD, 32'h00000007, 2'b00, 32'd0,
                  32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, "mult_neg");
    checkOutput("busy_in_run", {63'd0, busy}, 64'd1);
    repeat (4) @(negedge clk);
    op = OP_MULTU; src_a = 32'd5; src_b = 32'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("old_hi_while_busy", {32'd0, hi}, 64'hFFFFFFFE);
    checkOutput("old_lo_while_busy", {32'd0, lo}, 64'h00000001);
    waitIdle("mult_neg");

    applyStimulus(OP_MULT, 32'h80000000, 32'h80000000, 2'b00, 32'd0,
                  32'h40000000, 32'h00000000, 1'b0, "mult_minmin");
    waitIdle("mult_minmin");

    $display("[TB] MTHI/MTLO tests");
    writeHilo(2'b11, 32'h0F0F0F0F);
    checkOutput("mt_both_hi", {32'd0, hi}, 64'h0F0F0F0F);
    checkOutput("mt_both_lo", {32'd0, lo}, 64'h0F0F0F0F);
    writeHilo(2'b10, 32'h12345678);
    checkOutput("mthi_hi", {32'd0, hi}, 64'h12345678);
    checkOutput("mthi_lo", {32'd0, lo}, 64'h0F0F0F0F);

`ifdef MULDIV_DIV_EN
    $display("[TB] divide tests");
    applyStimulus(OP_DIVU, 32'd5, 32'd0, 2'b00, 32'd0,
                  32'h12345678, 32'h0F0F0F0F, 1'b1, "divu_by_zero");
    waitIdle("divu_by_zero");
    applyStimulus(OP_DIV, 32'hFFFFFFF9, 32'd2, 2'b00, 32'd0,
                  32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, "div_neg");
    waitIdle("div_neg");
    applyStimulus(OP_DIVU, 32'd100, 32'd7, 2'b00, 32'd0,
                  32'd2, 32'd14, 1'b0, "divu_100_7");
    waitIdle("divu_100_7");
    applyStimulus(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 2'b00, 32'd0,
                  32'h00000000, 32'h80000000, 1'b0, "div_overflow");
    waitIdle("div_overflow");
    prev_hi = 32'h00000000; prev_lo = 32'h80000000;
`else
    $display("[TB] divide requests in a build without divider");
    issueIgnored(OP_DIVU, "divu_ignored");
    issueIgnored(OP_DIV, "div_ignored");
    prev_hi = 32'h12345678; prev_lo = 32'h0F0F0F0F;
`endif

    $display("[TB] hilo writes around operations");
    applyStimulus(OP_MULTU, 32'd2, 32'd3, 2'b00, 32'd0,
                  32'd0, 32'd6, 1'b0, "mt_during_run");
    hilo_we = 2'b11; hilo_wdata = 32'hA5A5A5A5;
    repeat (3) @(negedge clk);
    hilo_we = 2'b00;
    checkOutput("mt_run_hi", {32'd0, hi}, {32'd0, prev_hi});
    checkOutput("mt_run_lo", {32'd0, lo}, {32'd0, prev_lo});
    waitIdle("mt_during_run");

    applyStimulus(OP_MULTU, 32'd9, 32'd9, 2'b11, 32'hA5A5A5A5,
                  32'd0, 32'd81, 1'b0, "start_with_mt");
    checkOutput("dropped_mt_hi", {32'd0, hi}, 64'd0);
    checkOutput("dropped_mt_lo", {32'd0, lo}, 64'd6);
    waitIdle("start_with_mt");

    $display("[TB] reset during operation");
    applyStimulus(OP_MULT, 32'd7, 32'hFFFFFFFE, 2'b00, 32'd0,
                  32'hFFFFFFFF, 32'hFFFFFFF2, 1'b0, "mult_aborted");
    repeat (9) @(posedge clk);
    #2 rst = 1'b0;
    sb.delete();
    #1;
    checkOutput("abort_busy", {63'd0, busy}, 64'd0);
    checkOutput("abort_done", {63'd0, done}, 64'd0);
    checkOutput("abort_hi", {32'd0, hi}, 64'd0);
    checkOutput("abort_lo", {32'd0, lo}, 64'd0);
    #1 rst = 1'b1;
    applyStimulus(OP_MULTU, 32'd3, 32'd4, 2'b00, 32'd0,
                  32'd0, 32'd12, 1'b0, "multu_after_reset");
    waitIdle("multu_after_reset");

    checkOutput("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
